// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the 8-digit 7-segment scan path.
//
// Contents:
//   NUM_DIGITS, DIG_W  - display geometry (8 digits, 3-bit digit select)
//   digit_t            - digit select
//   nibble_t           - one hex digit
//   disp_word_t        - full display value, nibble k drives digit k
//   dig_mask_t         - one bit per digit
//   lzs_mask()         - leading-zero suppression mask for a display word
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIG_W      = 3;

  typedef logic [DIG_W-1:0]        digit_t;
  typedef logic [3:0]              nibble_t;
  typedef logic [4*NUM_DIGITS-1:0] disp_word_t;
  typedef logic [NUM_DIGITS-1:0]   dig_mask_t;

  // Bit k is set when nibbles k..top are all zero. Walking down from the most
  // significant digit keeps a running "everything above is zero" flag.
  // Digit 0 is never suppressed so a value of zero still shows "0".
  function automatic dig_mask_t lzs_mask(input disp_word_t v);
    dig_mask_t m;
    logic      all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      all_zero = all_zero & (v[4*k +: 4] == 4'h0);
      m[k]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle enable pulse.
//
// Parameters:
//   SCAN_DIV - period of the tick in clk cycles (1 .. 2^DIV_W-1)
//   DIV_W    - width of the prescaler counter
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out high for one cycle out of every SCAN_DIV (every cycle when SCAN_DIV=1)
module tick_gen #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] count;

  // Tick is decoded from the registered count so it lands in the cycle the
  // count sits at its last value; the counter wraps on that same cycle.
  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller feeding the 7-segment decoder
// of the Nexys A7 8-digit display. Updates are double-buffered and only
// committed at a frame boundary so a frame never mixes old and new data.
//
// Optional feature: define SEG_SCAN_LZS_EN to enable leading-zero suppression.
//
// Parameters:
//   SCAN_DIV - clk cycles each digit is held
//   DIV_W    - prescaler counter width
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   capture value/digit_en into the shadow buffer
//   value      in   32-bit display value, nibble k -> digit k
//   digit_en   in   per-digit enable mask
//   dig        out  current digit select
//   data       out  nibble for the current digit
//   blank      out  1 = current digit dark
//   frame_tick out  one-cycle pulse when dig wraps 7->0
//   pending    out  shadow buffer holds an uncommitted update
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [31:0] value,
  input  logic [7:0] digit_en,
  output logic [2:0] dig,
  output logic [3:0] data,
  output logic       blank,
  output logic       frame_tick,
  output logic       pending
);

  logic       tick;
  logic       commit;
  disp_word_t shadow_value;
  dig_mask_t  shadow_mask;
  disp_word_t active_value;
  dig_mask_t  active_mask;
`ifdef SEG_SCAN_LZS_EN
  dig_mask_t  sup_mask;
`endif

  tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // The last tick of a frame is the only point where new data may go live.
  assign commit = tick && (dig == digit_t'(NUM_DIGITS - 1));

  // A load on the commit edge still lets the old shadow commit (it is read
  // before this edge updates it); the later pending<=1 wins so the new
  // shadow waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig          <= '0;
      frame_tick   <= 1'b0;
      pending      <= 1'b0;
      shadow_value <= '0;
      shadow_mask  <= '0;
      active_value <= '0;
      active_mask  <= '0;
`ifdef SEG_SCAN_LZS_EN
      sup_mask     <= '0;
`endif
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        dig <= dig + 1'b1;
      end
      if (commit) begin
        frame_tick <= 1'b1;
        if (pending) begin
          active_value <= shadow_value;
          active_mask  <= shadow_mask;
`ifdef SEG_SCAN_LZS_EN
          sup_mask     <= lzs_mask(shadow_value);
`endif
          pending      <= 1'b0;
        end
      end
      if (load) begin
        shadow_value <= value;
        shadow_mask  <= digit_en;
        pending      <= 1'b1;
      end
    end
  end

  assign data = active_value[{dig, 2'b00} +: 4];

`ifdef SEG_SCAN_LZS_EN
  assign blank = ~active_mask[dig] | sup_mask[dig];
`else
  assign blank = ~active_mask[dig];
`endif

endmodule
